// File: rtl/cache_rd_arbiter.sv
// rtl/cache_rd_arbiter.sv - round-robin icache/dcache arbiter onto a single AXI read port
module cache_rd_arbiter #(
  parameter logic [3:0] ICACHE_ARID = 4'd0,
  parameter logic [3:0] DCACHE_ARID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         i_rd_req,
  input  logic         i_rd_type,
  input  logic [31:0]  i_rd_addr,
  output logic         i_rd_rdy,
  output logic         i_ret_valid,
  output logic [255:0] i_ret_data,
  input  logic         d_rd_req,
  input  logic         d_rd_type,
  input  logic [31:0]  d_rd_addr,
  output logic         d_rd_rdy,
  output logic         d_ret_valid,
  output logic [255:0] d_ret_data,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready
);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_AR   = 4'b0010,
    S_R    = 4'b0100,
    S_RET  = 4'b1000
  } state_t;

  state_t         state, state_nxt;
  logic           owner;       // 0 = icache, 1 = dcache
  logic           line_type;
  logic [31:0]    addr_q;
  logic           last_grant;  // 0 = icache, 1 = dcache
  logic [2:0]     cnt;
  logic [255:0]   line_buf;
  logic           grant_i, grant_d;
  logic [255:0]   ret_data;

  // Completion is by beat count only, so these R-channel fields carry no information here.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast};

  assign arid     = owner ? DCACHE_ARID : ICACHE_ARID;
  assign araddr   = addr_q;
  assign arlen    = line_type ? 8'd7 : 8'd0;
  assign arsize   = 3'b010;
  assign arburst  = 2'b01;
  assign ret_data = line_type ? line_buf : {224'b0, line_buf[31:0]};
  assign i_ret_data = ret_data;
  assign d_ret_data = ret_data;

  always_comb begin
    state_nxt   = state;
    grant_i     = 1'b0;
    grant_d     = 1'b0;
    i_rd_rdy    = 1'b0;
    d_rd_rdy    = 1'b0;
    arvalid     = 1'b0;
    rready      = 1'b0;
    i_ret_valid = 1'b0;
    d_ret_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (resetn) begin
          // On a tie the side that did not win last time goes first.
          grant_d = d_rd_req & (~i_rd_req | ~last_grant);
          grant_i = i_rd_req & ~grant_d;
        end
        i_rd_rdy = grant_i;
        d_rd_rdy = grant_d;
        if (grant_i | grant_d) state_nxt = S_AR;
      end
      S_AR: begin
        arvalid = 1'b1;
        if (arready) state_nxt = S_R;
      end
      S_R: begin
        rready = 1'b1;
        if (rvalid && cnt == arlen[2:0]) state_nxt = S_RET;
      end
      S_RET: begin
        i_ret_valid = ~owner;
        d_ret_valid = owner;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= S_IDLE;
      owner      <= 1'b0;
      line_type  <= 1'b0;
      addr_q     <= 32'd0;
      last_grant <= 1'b0;
      cnt        <= 3'd0;
      line_buf   <= 256'd0;
    end else begin
      state <= state_nxt;
      if (grant_i | grant_d) begin
        owner      <= grant_d;
        line_type  <= grant_d ? d_rd_type : i_rd_type;
        addr_q     <= grant_d ? d_rd_addr : i_rd_addr;
        last_grant <= grant_d;
        cnt        <= 3'd0;
      end
      if (state == S_R && rvalid) begin
        line_buf[{cnt, 5'd0} +: 32] <= rdata;
        cnt <= cnt + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_rd_arbiter.sv
// tb/tb_cache_rd_arbiter.sv - directed bench with a transaction-level model checked every cycle
module tb_cache_rd_arbiter;

  logic         clk = 1'b0;
  logic         resetn;
  logic         i_rd_req, i_rd_type, d_rd_req, d_rd_type;
  logic [31:0]  i_rd_addr, d_rd_addr;
  logic         i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid;
  logic [255:0] i_ret_data, d_ret_data;
  logic [3:0]   arid, rid;
  logic [31:0]  araddr, rdata;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst, rresp;
  logic         arvalid, arready, rlast, rvalid, rready;

  int n_checks = 0;
  int n_fail   = 0;

  cache_rd_arbiter dut (
    .clk(clk), .resetn(resetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_data(d_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one outstanding request, its collected beats, and a return flag.
  bit          m_active, m_ar_done, m_ret, m_owner, m_type, m_last;
  logic [31:0] m_addr;
  logic [31:0] m_words[$];

  always @(negedge clk) begin
    bit idle, e_gi, e_gd;
    logic [255:0] e_data;
    if (!resetn) begin
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_i_ret_valid", i_ret_valid, 0);
      chk("rst_d_ret_valid", d_ret_valid, 0);
      chk("rst_i_rd_rdy", i_rd_rdy, 0);
      chk("rst_d_rd_rdy", d_rd_rdy, 0);
      m_active = 0; m_ar_done = 0; m_ret = 0; m_last = 0;
      m_words.delete();
    end else begin
      idle = !m_active && !m_ret;
      e_gd = idle && d_rd_req && (!i_rd_req || m_last == 1'b0);
      e_gi = idle && i_rd_req && !e_gd;
      chk("i_rd_rdy", i_rd_rdy, e_gi);
      chk("d_rd_rdy", d_rd_rdy, e_gd);
      chk("arvalid", arvalid, m_active && !m_ar_done);
      chk("rready", rready, m_active && m_ar_done);
      chk("i_ret_valid", i_ret_valid, m_ret && !m_owner);
      chk("d_ret_valid", d_ret_valid, m_ret && m_owner);
      chk("arsize", arsize, 3'b010);
      chk("arburst", arburst, 2'b01);
      if (m_active && !m_ar_done) begin
        chk("araddr", araddr, m_addr);
        chk("arlen", arlen, m_type ? 8'd7 : 8'd0);
        chk("arid", arid, m_owner ? 4'd1 : 4'd0);
      end
      if (m_ret) begin
        e_data = '0;
        foreach (m_words[i]) e_data[i*32 +: 32] = m_words[i];
        chk("ret_data", m_owner ? d_ret_data : i_ret_data, e_data);
      end
      // Advance the model across the coming rising edge.
      if (m_ret) begin
        m_ret = 0;
      end else if (e_gi || e_gd) begin
        m_active = 1; m_ar_done = 0; m_owner = e_gd; m_last = e_gd;
        m_type = e_gd ? d_rd_type : i_rd_type;
        m_addr = e_gd ? d_rd_addr : i_rd_addr;
        m_words.delete();
      end else if (m_active && !m_ar_done) begin
        if (arready) m_ar_done = 1;
      end else if (m_active && rvalid) begin
        m_words.push_back(rdata);
        if (m_words.size() == (m_type ? 8 : 1)) begin
          m_active = 0;
          m_ret = 1;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic request(input bit side, input bit typ, input logic [31:0] addr);
    if (side) begin
      d_rd_req = 1; d_rd_type = typ; d_rd_addr = addr;
    end else begin
      i_rd_req = 1; i_rd_type = typ; i_rd_addr = addr;
    end
  endtask

  task automatic wait_grant(input bit side);
    bit got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (side ? d_rd_rdy : i_rd_rdy) begin
        got = 1;
        break;
      end
    end
    chk("grant_timeout", got, 1);
    tick();
    if (side) d_rd_req = 0; else i_rd_req = 0;
  endtask

  task automatic serve(input int ar_wait, input int gap, input int n,
                       input logic [31:0] base, input int rlast_at);
    bit got = 0;
    if (ar_wait > 0) begin
      arready = 0;
      repeat (ar_wait) tick();
    end
    arready = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rready) begin
        got = 1;
        break;
      end
    end
    chk("rready_timeout", got, 1);
    tick();
    for (int b = 0; b < n; b++) begin
      if (b > 0) begin
        rvalid = 0;
        repeat (gap) tick();
      end
      rvalid = 1;
      rdata  = base + b;
      rlast  = (b == rlast_at);
      tick();
    end
    rvalid = 0;
    rlast  = 0;
  endtask

  task automatic do_reset;
    resetn = 0;
    tick();
    tick();
    resetn = 1;
  endtask

  initial begin
    logic [255:0] line_lit;
    resetn = 0;
    i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
    d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
    arready = 1; rid = 4'hF; rdata = 0; rresp = 2'b10; rlast = 0; rvalid = 0;
    #1;
    chk("reset_arvalid", arvalid, 0);
    chk("reset_rready", rready, 0);
    repeat (3) tick();
    resetn = 1;
    tick();
    chk("idle_no_req_rdy", i_rd_rdy, 0);

    // Icache line fill
    request(0, 1, 32'h1FC0_0020);
    @(negedge clk);
    chk("t1_i_rd_rdy", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    chk("t1_arvalid", arvalid, 1);
    chk("t1_araddr", araddr, 32'h1FC0_0020);
    chk("t1_arlen", arlen, 8'd7);
    chk("t1_arid", arid, 4'd0);
    serve(0, 0, 8, 32'h0, -1);
    line_lit = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
    chk("t1_i_ret_valid", i_ret_valid, 1);
    chk("t1_i_ret_data", i_ret_data, line_lit);
    tick();
    chk("t1_ret_pulse_end", i_ret_valid, 0);

    // Dcache uncached word
    request(1, 0, 32'hBFAF_8000);
    wait_grant(1);
    chk("t2_arlen", arlen, 8'd0);
    chk("t2_arid", arid, 4'd1);
    serve(0, 0, 1, 32'hDEAD_BEEF, -1);
    chk("t2_d_ret_valid", d_ret_valid, 1);
    chk("t2_d_ret_data", d_ret_data, {224'b0, 32'hDEAD_BEEF});
    chk("t2_i_ret_valid", i_ret_valid, 0);
    tick();

    // Ties after a fresh reset
    do_reset();
    request(0, 1, 32'h0000_0100);
    request(1, 0, 32'h0000_0200);
    @(negedge clk);
    chk("t3_tie1_d_rdy", d_rd_rdy, 1);
    chk("t3_tie1_i_rdy", i_rd_rdy, 0);
    tick();
    d_rd_req = 0;
    serve(0, 0, 1, 32'hA0, -1);
    tick();
    @(negedge clk);
    chk("t3_i_after_ret", i_rd_rdy, 1);
    tick();
    i_rd_req = 0;
    serve(0, 0, 8, 32'h10, -1);
    chk("t3_i_ret_word7", i_ret_data[255:224], 32'h17);
    tick();
    request(0, 0, 32'h0000_0300);
    request(1, 0, 32'h0000_0400);
    @(negedge clk);
    chk("t3_tie3_d_rdy", d_rd_rdy, 1);
    chk("t3_tie3_i_rdy", i_rd_rdy, 0);
    tick();
    d_rd_req = 0;
    i_rd_req = 0;
    serve(0, 0, 1, 32'hB0, -1);
    tick();

    // Backpressure on AR and gaps on R
    request(0, 1, 32'h0000_2000);
    wait_grant(0);
    serve(5, 3, 8, 32'h40, -1);
    chk("t4_i_ret_valid", i_ret_valid, 1);
    chk("t4_word0", i_ret_data[31:0], 32'h40);
    chk("t4_word7", i_ret_data[255:224], 32'h47);
    tick();

    // rlast on the fourth beat does not end the burst
    request(1, 1, 32'h0000_3000);
    wait_grant(1);
    serve(0, 0, 4, 32'h80, 3);
    chk("t6_no_early_ret", d_ret_valid, 0);
    chk("t6_still_rready", rready, 1);
    serve(0, 0, 4, 32'h84, -1);
    chk("t6_d_ret_valid", d_ret_valid, 1);
    chk("t6_word7", d_ret_data[255:224], 32'h87);
    tick();

    // Asynchronous reset in the middle of R
    request(0, 1, 32'h0000_4000);
    wait_grant(0);
    serve(0, 0, 3, 32'h50, -1);
    chk("t5_rready_before", rready, 1);
    #2;
    resetn = 0;
    #1;
    chk("t5_arvalid", arvalid, 0);
    chk("t5_rready", rready, 0);
    chk("t5_i_ret_valid", i_ret_valid, 0);
    chk("t5_d_ret_valid", d_ret_valid, 0);
    @(posedge clk);
    #3;
    resetn = 1;
    request(0, 1, 32'h0000_5000);
    wait_grant(0);
    serve(0, 0, 8, 32'h60, -1);
    chk("t5_i_ret_valid_after", i_ret_valid, 1);
    chk("t5_word0", i_ret_data[31:0], 32'h60);
    chk("t5_word7", i_ret_data[255:224], 32'h67);
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_rd_arbiter.md
Name: cache_rd_arbiter

Overview:
Shares the single AXI read port between the instruction cache and the data cache refill/uncached-read interfaces (rd_req/rd_type/rd_addr/rd_rdy/ret_valid/ret_data).
Arbitrates round-robin and issues one AXI AR burst at a time: 8 beats for a cache line, 1 beat for an uncached word.
Assembles the returned 32-bit beats into a 256-bit line and returns it to the owning cache with a one-cycle ret_valid pulse.
Sits between the two caches and the AXI crossbar/bridge.

Parameters:
ICACHE_ARID, 4'd0, arid driven for icache transactions
DCACHE_ARID, 4'd1, arid driven for dcache transactions

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
i_rd_req  in  1  icache read request
i_rd_type  in  1  0 = uncached word, 1 = cache line
i_rd_addr  in  32  icache read address (line-aligned when type = 1)
i_rd_rdy  out  1  icache request accepted (same cycle as i_rd_req)
i_ret_valid  out  1  icache return pulse
i_ret_data  out  256  icache return data
d_rd_req, d_rd_type, d_rd_addr, d_rd_rdy, d_ret_valid, d_ret_data  same as i_*  dcache side
arid  out  4  AXI AR id
araddr  out  32  AXI AR address
arlen  out  8  7 for a line, 0 for a word
arsize  out  3  always 3'b010
arburst  out  2  always 2'b01 (INCR)
arvalid  out  1  AXI AR valid
arready  in  1  AXI AR ready
rid  in  4  AXI R id (ignored)
rdata  in  32  AXI R data
rresp  in  2  AXI R response (ignored)
rlast  in  1  AXI R last (ignored, see Behaviour)
rvalid  in  1  AXI R valid
rready  out  1  AXI R ready

Behaviour:
- The clock is clk. Reset is asynchronous, active-low, on resetn.
- Reset values:
  - state = IDLE.
  - arvalid, rready, i_rd_rdy, d_rd_rdy, i_ret_valid and d_ret_valid are 0.
  - last_grant = icache.
  - Beat counter = 0.
  - Line buffer = 0.
- States are one-hot: IDLE, AR, R, RET.
- IDLE:
  - Grant is combinational.
  - Only one requester asserting rd_req: it is granted.
  - Both asserting: the one not equal to last_grant is granted, so the first tie after reset goes to dcache.
  - The granted side's rd_rdy = 1 in the same cycle; the other side's rd_rdy = 0. rd_rdy is 0 in every non-IDLE state.
  - On grant:
    - Latch owner, type and addr.
    - Update last_grant to the owner.
    - Clear the beat counter.
    - Go to AR.
- AR:
  - arvalid = 1.
  - araddr = latched addr.
  - arid = owner's ID parameter.
  - arlen = type ? 8'd7 : 8'd0.
  - Outputs are stable while arvalid && !arready.
  - On arready go to R; arvalid drops the next cycle.
- R:
  - rready = 1.
  - Each rvalid beat writes rdata into buffer word[cnt] (word 0 = bits 31:0), then cnt increments.
  - On the beat where cnt == arlen, go to RET.
  - rlast, rid and rresp are not checked; completion is by count only.
- RET (exactly one cycle):
  - The owner's ret_valid = 1.
  - ret_data = full buffer for a line.
  - ret_data = {224'b0, word0} for an uncached word.
  - The non-owner's ret_valid stays 0.
  - Next state is IDLE.
  - A new grant is possible no earlier than the cycle after RET.
- Latency:
  - Request accept to arvalid = 1 cycle.
  - Last R beat to ret_valid = 1 cycle.
- ret_data of both sides continuously drives the buffer-based value. It is only meaningful while ret_valid = 1.
- Requests arriving outside IDLE are held by the cache (its rd_req stays high) and served after return to IDLE.
- Reset mid-operation: all state is abandoned immediately and the outputs take their reset values. In-flight AXI beats are not drained; the interconnect is reset by the same resetn.
- Only one outstanding AXI read at any time.

Test Plan:
1. Icache only: i_rd_req = 1, type = 1, addr = 0x1FC0_0020 in IDLE.
   - Required: i_rd_rdy = 1 the same cycle.
   - Next cycle: arvalid = 1, araddr = 0x1FC00020, arlen = 7, arid = 0.
   - Feed beats 0x0 to 0x7 with rvalid = 1 back to back.
   - Required: one cycle after the 8th beat, i_ret_valid = 1 for exactly one cycle and i_ret_data = {32'h7, ..., 32'h0}.
2. Dcache uncached: d_rd_req = 1, type = 0, addr = 0xBFAF_8000, rdata = 0xDEADBEEF.
   - Required: arlen = 0, arid = 1.
   - Required: d_ret_valid pulse with d_ret_data = {224'b0, 32'hDEADBEEF}; i_ret_valid stays 0 throughout.
3. Tie after reset: both rd_req = 1 in the same cycle.
   - Required: dcache granted first (d_rd_rdy = 1, i_rd_rdy = 0).
   - After the dcache RET: icache granted in the next IDLE cycle.
   - Third tie: dcache granted again.
4. Backpressure: hold arready = 0 for 5 cycles, and insert rvalid gaps of 3 cycles between beats.
   - Required: araddr, arlen and arid stay stable while waiting; exactly 8 beats are consumed.
   - Required: ret_valid only after the 8th beat; rready = 1 throughout R.
5. Async reset mid-R: assert resetn = 0 after 3 beats, between clock edges.
   - Required: arvalid, rready and both ret_valid go to 0 immediately.
   - After release: state = IDLE; a new icache request is granted and returns correct data.
6. rlast misuse: assert rlast on beat 4 of a line.
   - Required: the transfer still completes after 8 beats; ret_valid only after beat 8.
